// File: rtl/ejecutor_instrucciones_pkg.sv
// Shared definitions for the instruction execution unit.
// Contents: instruction field positions, opcode constants, FSM state
// encoding, the debug struct exposed by the top, and small field helpers.
package ejecutor_instrucciones_pkg;

  localparam int INSTR_W = 16;

  // Instruction word layout: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb.
  // LDI reuses [7:0] as an 8-bit immediate.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    MUL  = 3'd2,
    WB   = 3'd3,
    FIN  = 3'd4
  } state_t;

  typedef struct packed {
    state_t     state;
    logic       mul_busy;
    logic [3:0] op;
  } dbg_t;

  function automatic logic [3:0] f_op(input logic [INSTR_W-1:0] i);
    return i[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [3:0] f_rd(input logic [INSTR_W-1:0] i);
    return i[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [3:0] f_ra(input logic [INSTR_W-1:0] i);
    return i[RA_MSB:RA_LSB];
  endfunction

  function automatic logic [3:0] f_rb(input logic [INSTR_W-1:0] i);
    return i[RB_MSB:RB_LSB];
  endfunction

  function automatic logic [7:0] f_imm(input logic [INSTR_W-1:0] i);
    return i[IMM_MSB:IMM_LSB];
  endfunction

  // Opcodes 10..15 are reserved and retire with err.
  function automatic logic f_legal(input logic [3:0] op);
    return op <= OP_LDI;
  endfunction

endpackage

// File: rtl/ejecutor_instrucciones_if.sv
// Bus between the execution unit and its environment (instruction source
// plus 16x16 register file).
// Handshake: an instruction transfers on a rising clk edge where both
// instr_valid and instr_ready are 1; instr must be stable while instr_valid
// is high; instr_ready is asserted only while the unit is idle.
// Signals: instr_valid/instr (to unit), instr_ready (from unit),
// regs_flat (register file outputs, r1 in LSBs), w/select_register/s
// (register file write port), done/err (retire pulses).
// Modports: master = instruction source / register file, slave = unit.
interface ejecutor_instrucciones_if #(
  parameter int N    = 16,
  parameter int NREG = 16
);
  logic            instr_valid;
  logic [15:0]     instr;
  logic            instr_ready;
  logic [NREG*N-1:0] regs_flat;
  logic            w;
  logic [3:0]      select_register;
  logic [N-1:0]    s;
  logic            done;
  logic            err;

  modport master (
    output instr_valid, instr, regs_flat,
    input  instr_ready, w, select_register, s, done, err
  );

  modport slave (
    input  instr_valid, instr, regs_flat,
    output instr_ready, w, select_register, s, done, err
  );
endinterface

// File: rtl/ejecutor_instrucciones_mult.sv
// mult_secuencial: N-cycle shift-add multiplier returning the low N bits of
// a*b.
// Ports: clk, rst (async, active-high), start (load a/b and begin),
// a, b (operands), busy (iterations remaining), done (high during the last
// iteration cycle), result (accumulator after the current iteration).
// result is combinational so the caller can capture the final product on
// the same edge that finishes the last iteration.
module mult_secuencial
  import ejecutor_instrucciones_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  mcand_q;
  logic [N-1:0]  mplier_q;
  logic [N-1:0]  acc_q;
  logic [CW-1:0] count_q;
  logic [N-1:0]  acc_next;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      count_q  <= CW'(N);
    end else if (busy) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q - CW'(1);
    end
  end

  assign busy   = (count_q != '0);
  assign done   = (count_q == CW'(1));
  assign result = acc_next;

endmodule

// File: rtl/ejecutor_instrucciones.sv
// ejecutor_instrucciones: multi-cycle execution unit in front of a 16x16
// register file. Takes one instruction at a time, reads operands from the
// file's parallel outputs, and writes the result back through w /
// select_register / s for one cycle.
// Ports: clk, rst (async, active-high), bus (slave side of
// ejecutor_instrucciones_if), dbg (FSM state, multiplier busy, latched op).
// Flow: IDLE -accept-> EXEC -> {WB | MUL x N -> WB | FIN} -> IDLE.
// All bus outputs are registered, so rst clears w asynchronously.
module ejecutor_instrucciones
  import ejecutor_instrucciones_pkg::*;
#(
  parameter int N    = 16,
  parameter int NREG = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  ejecutor_instrucciones_if.slave  bus,
  output dbg_t                     dbg
);

  state_t            state_q, state_d;
  logic [15:0]       instr_q;
  logic [NREG*N-1:0] regs;

  logic [3:0]   op, rd, ra, rb;
  logic [N-1:0] opa, opb;
  logic [N-1:0] alu_res;
  logic [N-1:0] wb_data;
  logic         op_legal;

  logic         mul_start;
  logic         mul_busy;
  logic         mul_done;
  logic [N-1:0] mul_res;

  logic         w_q, done_q, err_q;
  logic [3:0]   sel_q;
  logic [N-1:0] s_q;

  assign regs     = bus.regs_flat;
  assign op       = f_op(instr_q);
  assign rd       = f_rd(instr_q);
  assign ra       = f_ra(instr_q);
  assign rb       = f_rb(instr_q);
  assign op_legal = f_legal(op);

  // Register k (0-based) occupies bits [k*N +: N].
  assign opa = regs[int'(ra)*N +: N];
  assign opb = regs[int'(rb)*N +: N];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SHL:  alu_res = opa << 1;
      OP_SHR:  alu_res = opa >> 1;
      OP_LDI:  alu_res = N'(f_imm(instr_q));
      default: alu_res = '0;
    endcase
  end

  mult_secuencial #(.N(N)) u_mult (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (opa),
    .b      (opb),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_res)
  );

  // Leaving MUL the product comes from the multiplier; leaving EXEC it is
  // the single-cycle ALU.
  assign wb_data = (state_q == MUL) ? mul_res : alu_res;

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: if (bus.instr_valid) state_d = EXEC;
      EXEC: begin
        if (!op_legal || op == OP_NOP) begin
          state_d = FIN;
        end else if (op == OP_MUL) begin
          mul_start = 1'b1;
          state_d   = MUL;
        end else begin
          state_d = WB;
        end
      end
      MUL:     if (mul_done) state_d = WB;
      WB:      state_d = IDLE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      w_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.instr_valid) instr_q <= bus.instr;
      // Outputs are decoded from the next state so they line up with it.
      w_q    <= (state_d == WB);
      done_q <= (state_d == WB) || (state_d == FIN);
      err_q  <= (state_d == FIN) && !op_legal;
      if (state_d == WB) begin
        sel_q <= rd;
        s_q   <= wb_data;
      end
    end
  end

  assign bus.instr_ready     = (state_q == IDLE);
  assign bus.w               = w_q;
  assign bus.select_register = sel_q;
  assign bus.s               = s_q;
  assign bus.done            = done_q;
  assign bus.err             = err_q;

  assign dbg.state    = state_q;
  assign dbg.mul_busy = mul_busy;
  assign dbg.op       = op;

endmodule

// File: doc/ejecutor_instrucciones.md
Name: ejecutor_instrucciones

Overview:
- Multi-cycle execution unit sitting directly upstream of the 16x16-bit register file.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and reads operands from the register file's 16 parallel outputs.
- Computes the result and drives the file's write port (w, select_register, s) for exactly one cycle per writing instruction.
- Only one instruction is in flight at a time, so there are no read-after-write hazards.

Parameters:
- N, 16: data width of registers, operands and result.
- NREG, 16: number of registers. Fixed by the 4-bit register index; not to be changed.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction present on instr.
- instr  input  16  instruction word. [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb; [7:0] is imm8 for LDI.
- instr_ready  output  1  unit can accept an instruction.
- regs_flat  input  NREG*N  register file outputs concatenated. r1 in bits [N-1:0], r16 in the MSBs; index k selects bits [k*N+N-1:k*N].
- w  output  1  register file write enable.
- select_register  output  4  destination register index.
- s  output  N  write data.
- done  output  1  one-cycle pulse when an instruction retires (with or without a write).
- err  output  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Reset values: state=IDLE, instr_ready=1, w=0, select_register=0, s=0, done=0, err=0. All internal registers cleared.
- Accept occurs on a rising edge where instr_valid && instr_ready. instr is latched and the state goes to EXEC.
- instr_ready is 1 only in IDLE. instr is ignored in all other states.
- Opcodes:
  - 0 NOP
  - 1 ADD ra+rb
  - 2 SUB ra-rb
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL ra<<1
  - 7 SHR ra>>1 (logical)
  - 8 MUL, low N bits of ra*rb
  - 9 LDI rd = zero-extended imm8
  - 10-15 illegal
- Arithmetic is modulo 2^N. No carry or overflow outputs.
- EXEC (1 cycle):
  - Operands are sampled from regs_flat using the latched ra/rb.
  - Single-cycle ops register the result and go to WB.
  - MUL loads multiplicand=ra, multiplier=rb, acc=0, count=N and goes to MUL.
  - NOP and illegal opcodes go to FIN.
- MUL (N cycles), each cycle:
  - If multiplier[0], then acc += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; count -= 1.
  - When count reaches 0, go to WB with result = acc.
- WB (1 cycle): w=1, select_register=rd, s=result, done=1. Next state is IDLE.
- FIN (1 cycle): w=0, done=1; err=1 if the opcode is illegal. Next state is IDLE.
- Latency from the accept edge:
  - ALU ops, LDI, NOP and illegal: retire in cycle 2 (EXEC, then WB/FIN). instr_ready returns in cycle 3.
  - MUL: retires in cycle N+2.
- Outside WB: w=0, and select_register/s hold their last values.
- rd equal to ra or rb is legal. Operands are already captured, and the new value is visible to the next instruction.
- instr_valid held high continuously: a back-to-back accept happens on the first IDLE edge. Throughput is one instruction per 3 cycles for ALU ops.
- rst asserted in any state, including mid-MUL or during WB:
  - Immediate return to IDLE, w drops to 0 asynchronously, and the in-flight instruction is discarded (no write).
  - Simultaneous rst and accept: reset wins.

Decomposition:
- Shared package holds:
  - opcode constants (OP_NOP..OP_LDI);
  - state encoding (IDLE, EXEC, MUL, WB, FIN);
  - instruction field bit positions.
- One sub-module, mult_secuencial: N-cycle shift-add multiplier with start/busy/done and an N-bit result output. It is reset by rst.
- The operand mux and single-cycle ALU stay inline.

Test Plan:
- Registers at their reset contents (r1=0x0042, r2=0x0021). Issue ADD rd=5, ra=0, rb=1 -> w=1 in cycle 2 with select_register=5, s=0x0063, done=1; instr_ready=1 in cycle 3.
- SUB rd=8, ra=0, rb=1 -> s=0x0021. Then SUB ra=1, rb=0 -> s=0xFFDF (wrap).
- r3=0x000D, r4=0x0007. Issue MUL rd=6, ra=2, rb=3 -> w asserted exactly in cycle N+2=18 with s=0x005B; instr_ready=0 for cycles 1-18.
- LDI rd=15 imm8=0xA5 -> s=0x00A5, select_register=15. Then opcode 12 -> err=1, done=1, w never asserted.
- instr_valid held high with 3 queued ADDs -> exactly 3 w pulses, 3 cycles apart. With instr_valid low, nothing is accepted and w stays 0.
- rst pulsed at MUL cycle 7 -> w=0, state IDLE, no write, instr_ready=1. A following ADD executes normally.
